// File: rtl/add_unit_arbiter_pkg.sv
// add_unit_arbiter_pkg
//   Shared constants and types for the shared-adder arbiter slice.
//   ARB_WORD_W  : processor word width (12)
//   ARB_ADD_W   : width of the shared carry-lookahead adder (8)
//   ARB_MAX_REQ : largest supported requester count (4)
//   req_id_t    : requester index, wide enough for ARB_MAX_REQ requesters
//   grant_t     : one-hot grant vector, one bit per possible requester
package add_unit_arbiter_pkg;

    localparam int ARB_WORD_W  = 12;
    localparam int ARB_ADD_W   = 8;
    localparam int ARB_MAX_REQ = 4;

    typedef logic [$clog2(ARB_MAX_REQ)-1:0] req_id_t;
    typedef logic [ARB_MAX_REQ-1:0]         grant_t;

    function automatic grant_t id_to_grant(input req_id_t id);
        return grant_t'(1) << id;
    endfunction

endpackage

// File: rtl/add_unit_core.sv
// add_unit_core
//   Combinational 8-bit carry-lookahead adder built from two 4-bit
//   lookahead groups. The carry out of the top group is never formed:
//   the processor's add convention drops it.
//   a, b : 8-bit operands
//   sum  : (a + b) mod 256
module add_unit_core
    import add_unit_arbiter_pkg::*;
(
    input  logic [ARB_ADD_W-1:0] a,
    input  logic [ARB_ADD_W-1:0] b,
    output logic [ARB_ADD_W-1:0] sum
);

    // Bit 7 generate would only feed the discarded carry out.
    logic [6:0] g;
    logic [7:0] p;
    logic [7:0] c;
    logic       grp0_g;

    // Carries into bits 0..3 of a 4-bit group, fully looked ahead from cin.
    function automatic logic [3:0] cla4(input logic [2:0] gi,
                                        input logic [2:0] pi,
                                        input logic       cin);
        logic [3:0] cv;
        cv[0] = cin;
        cv[1] = gi[0] | (pi[0] & cin);
        cv[2] = gi[1] | (pi[1] & gi[0]) | (pi[1] & pi[0] & cin);
        cv[3] = gi[2] | (pi[2] & gi[1]) | (pi[2] & pi[1] & gi[0])
              | (pi[2] & pi[1] & pi[0] & cin);
        return cv;
    endfunction

    assign g = a[6:0] & b[6:0];
    assign p = a ^ b;

    // Group-0 generate is the carry into the upper group (carry-in is 0).
    assign grp0_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                  | (p[3] & p[2] & p[1] & g[0]);

    assign c[3:0] = cla4(g[2:0], p[2:0], 1'b0);
    assign c[7:4] = cla4(g[6:4], p[6:4], grp0_g);

    assign sum = p ^ c;

endmodule

// File: rtl/add_unit_arbiter.sv
// add_unit_arbiter
//   Shares one 8-bit adder between NUM_REQ requesters. A requester is
//   granted when the result register is free (empty or being drained);
//   the granted operands go through the adder and the zero-extended sum
//   is registered together with the winner's ID.
//
//   Build option ADD_ARB_FIXED_PRIO_EN: when defined, the lowest-index
//   valid requester always wins and no rotation pointer exists. When
//   undefined (default), the search starts at the requester after the
//   last winner (round-robin).
//
//   clk, rst_n            : clock, asynchronous active-low reset
//   req_valid / req_ready : per-requester handshake (req_ready one-hot)
//   req_op_a / req_op_b   : packed operands, requester i at [i*WORD_W +: WORD_W]
//   rsp_valid / rsp_ready : result handshake
//   rsp_result            : {zeros, (a[7:0] + b[7:0]) mod 256}
//   rsp_id                : index of the requester that produced rsp_result
module add_unit_arbiter
    import add_unit_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int WORD_W  = ARB_WORD_W,
    parameter int ADD_W   = ARB_ADD_W,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*WORD_W-1:0] req_op_a,
    input  logic [NUM_REQ*WORD_W-1:0] req_op_b,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [WORD_W-1:0]         rsp_result,
    output logic [ID_W-1:0]           rsp_id
);

    logic              vld_p1;
    logic [WORD_W-1:0] result_p1;
    logic [ID_W-1:0]   id_p1;

    req_id_t           start;
    req_id_t           idx;
    req_id_t           win;
    logic              found;
    grant_t            valid_ext;
    grant_t            grant;
    logic              slot_free;
    logic              xfer;
    logic [WORD_W-1:0] a_sel;
    logic [WORD_W-1:0] b_sel;
    logic [ADD_W-1:0]  sum_p0;
    logic              unused_hi;

    function automatic logic [WORD_W-1:0] zero_ext(input logic [ADD_W-1:0] s);
        return {{(WORD_W-ADD_W){1'b0}}, s};
    endfunction

`ifdef ADD_ARB_FIXED_PRIO_EN
    assign start = '0;
`else
    req_id_t ptr_p1;

    // The pointer only moves on a transfer, so idle cycles keep the
    // rotation position and a waiting requester loses at most NUM_REQ-1 turns.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_p1 <= '0;
        end else if (xfer) begin
            ptr_p1 <= req_id_t'((int'(win) + 1) % NUM_REQ);
        end
    end

    assign start = ptr_p1;
`endif

    // ---- stage p0: arbitration, operand mux, shared adder ----
    assign valid_ext = grant_t'(req_valid);

    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = req_id_t'((int'(start) + k) % NUM_REQ);
            if (!found && valid_ext[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    assign grant     = found ? id_to_grant(win) : '0;
    assign slot_free = !vld_p1 || rsp_ready;
    // rst_n gates the grant so no requester sees ready while held in reset.
    assign xfer      = found && slot_free && rst_n;
    assign req_ready = xfer ? grant[NUM_REQ-1:0] : '0;

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            a_sel = a_sel | (req_op_a[i*WORD_W +: WORD_W] & {WORD_W{grant[i]}});
            b_sel = b_sel | (req_op_b[i*WORD_W +: WORD_W] & {WORD_W{grant[i]}});
        end
    end

    add_unit_core u_core (
        .a   (a_sel[ADD_W-1:0]),
        .b   (b_sel[ADD_W-1:0]),
        .sum (sum_p0)
    );

    // Operand bits above the adder width are architecturally ignored.
    assign unused_hi = ^{a_sel[WORD_W-1:ADD_W], b_sel[WORD_W-1:ADD_W], grant};

    // ---- stage p1: result register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1    <= 1'b0;
            result_p1 <= '0;
            id_p1     <= '0;
        end else if (xfer) begin
            vld_p1    <= 1'b1;
            result_p1 <= zero_ext(sum_p0);
            id_p1     <= win[ID_W-1:0];
        end else if (rsp_ready) begin
            vld_p1    <= 1'b0;
        end
    end

    assign rsp_valid  = vld_p1;
    assign rsp_result = result_p1;
    assign rsp_id     = id_p1;

endmodule

// File: tb/tb_add_unit_arbiter.sv
// tb_add_unit_arbiter
//   Bench for add_unit_arbiter: a four-requester instance driven by
//   directed and random stimulus against a transaction-level model, plus
//   a two-requester instance for the single-requester case.
module tb_add_unit_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;

    logic [3:0]  valid;
    logic [3:0]  ready;
    logic [47:0] op_a;
    logic [47:0] op_b;
    logic        rsp_ready;
    logic        rsp_valid;
    logic [11:0] rsp_result;
    logic [1:0]  rsp_id;

    logic [1:0]  v2;
    logic [1:0]  rdy2;
    logic [23:0] a2;
    logic [23:0] b2;
    logic        rr2;
    logic        vld2;
    logic [11:0] res2;
    logic [0:0]  id2;

    int errors = 0;
    int checks = 0;

    // reference model state
    bit       m_vld;
    bit [11:0] m_res;
    int       m_id;
    int       m_ptr;
    int       last_grant;

    always #5 clk = ~clk;

    add_unit_arbiter #(.NUM_REQ(4)) dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (valid),
        .req_ready  (ready),
        .req_op_a   (op_a),
        .req_op_b   (op_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_id     (rsp_id)
    );

    add_unit_arbiter #(.NUM_REQ(2)) dut2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (v2),
        .req_ready  (rdy2),
        .req_op_a   (a2),
        .req_op_b   (b2),
        .rsp_valid  (vld2),
        .rsp_ready  (rr2),
        .rsp_result (res2),
        .rsp_id     (id2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // First valid requester at or after 'start', wrapping; -1 if none.
    function automatic int pick(input logic [3:0] v, input int start);
        for (int k = 0; k < 4; k++) begin
            int i;
            i = (start + k) % 4;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_vld = 0;
        m_res = '0;
        m_id  = 0;
        m_ptr = 0;
    endtask

    // Called at a falling edge with inputs already driven.
    task automatic step(input string tag);
        int         g;
        bit         sf;
        logic [3:0] exp_rdy;
        logic [7:0] s;
        #1;
        sf = !m_vld || rsp_ready;
`ifdef ADD_ARB_FIXED_PRIO_EN
        g = pick(valid, 0);
`else
        g = pick(valid, m_ptr);
`endif
        exp_rdy = (sf && g >= 0) ? (4'b0001 << g) : 4'b0000;
        check({tag, ":ready"}, 32'(ready), 32'(exp_rdy));
        last_grant = (exp_rdy != 0) ? g : -1;
        if (exp_rdy != 0) begin
            s     = op_a[g*12 +: 8] + op_b[g*12 +: 8];
            m_vld = 1;
            m_res = {4'h0, s};
            m_id  = g;
            m_ptr = (g + 1) % 4;
        end else if (rsp_ready) begin
            m_vld = 0;
        end
        @(posedge clk);
        #1;
        check({tag, ":rsp_valid"},  32'(rsp_valid),  32'(m_vld));
        check({tag, ":rsp_result"}, 32'(rsp_result), 32'(m_res));
        check({tag, ":rsp_id"},     32'(rsp_id),     32'(m_id));
        @(negedge clk);
    endtask

    task automatic rand_ops();
        op_a = 48'({$urandom(), $urandom()});
        op_b = 48'({$urandom(), $urandom()});
    endtask

    // Entered and left at a falling edge.
    task automatic do_reset();
        rst_n     = 1'b0;
        valid     = 4'hF;
        rsp_ready = 1'b1;
        #1;
        check("reset:ready", 32'(ready), 32'h0);
        @(posedge clk);
        #1;
        check("reset:rsp_valid",  32'(rsp_valid),  32'h0);
        check("reset:rsp_result", 32'(rsp_result), 32'h0);
        check("reset:rsp_id",     32'(rsp_id),     32'h0);
        @(negedge clk);
        valid = 4'h0;
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        rst_n     = 1'b0;
        valid     = '0;
        op_a      = '0;
        op_b      = '0;
        rsp_ready = 1'b1;
        v2        = '0;
        a2        = '0;
        b2        = '0;
        rr2       = 1'b1;
        model_reset();
        @(negedge clk);
        do_reset();

        // idle after reset
        for (int i = 0; i < 3; i++) step("idle");

        // two-requester instance: requester 1 alone
        v2 = 2'b10;
        a2 = {12'h012, 12'h000};
        b2 = {12'h034, 12'h000};
        #1;
        check("n2:ready", 32'(rdy2), 32'h2);
        @(posedge clk);
        #1;
        check("n2:rsp_valid",  32'(vld2), 32'h1);
        check("n2:rsp_result", 32'(res2), 32'h046);
        check("n2:rsp_id",     32'(id2),  32'h1);
        @(negedge clk);
        v2 = 2'b00;
        @(posedge clk);
        #1;
        check("n2:drained", 32'(vld2), 32'h0);
        @(negedge clk);

        // carry dropped and high operand bits ignored
        valid = 4'b0001;
        op_a  = '0;
        op_b  = '0;
        op_a[11:0] = 12'hFFF;
        op_b[11:0] = 12'h001;
        step("ovf1");
        check("ovf1:result", 32'(rsp_result), 32'h000);
        op_a[11:0] = 12'h980;
        op_b[11:0] = 12'h380;
        step("ovf2");
        check("ovf2:result", 32'(rsp_result), 32'h000);
        valid = 4'b0000;
        step("ovf:idle");

        // all four valid, drain every cycle
        do_reset();
        valid = 4'hF;
        for (int k = 0; k < 5; k++) begin
            int exp_g;
            rand_ops();
`ifdef ADD_ARB_FIXED_PRIO_EN
            exp_g = 0;
`else
            exp_g = k % 4;
`endif
            step("rr");
            check("rr:grant_seq", 32'(last_grant), 32'(exp_g));
            check("rr:id_seq",    32'(rsp_id),     32'(exp_g));
        end

        // backpressure: result held, no grants, then drain+accept together
        do_reset();
        valid = 4'b0001;
        op_a  = '0;
        op_b  = '0;
        op_a[11:0] = 12'h0AB;
        op_b[11:0] = 12'h011;
        rsp_ready = 1'b0;
        step("bp:load");
        valid = 4'hF;
        for (int k = 0; k < 3; k++) begin
            rand_ops();
            step("bp:stall");
            check("bp:held_result", 32'(rsp_result), 32'h0BC);
            check("bp:held_id",     32'(rsp_id),     32'h0);
        end
        valid = 4'b0100;
        rsp_ready = 1'b1;
        rand_ops();
        step("bp:release");
        check("bp:release_grant", 32'(last_grant), 32'h2);
        check("bp:release_valid", 32'(rsp_valid),  32'h1);

        // reset asserted while a result is stalled
        valid = 4'b0001;
        rsp_ready = 1'b0;
        step("mid:load");
        valid = 4'b0000;
        step("mid:stall");
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_reset:rsp_valid",  32'(rsp_valid),  32'h0);
        check("mid_reset:rsp_result", 32'(rsp_result), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // sparse: requesters 1 and 3 only
        valid = 4'b1010;
        rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            int exp_g;
            rand_ops();
`ifdef ADD_ARB_FIXED_PRIO_EN
            exp_g = 1;
`else
            exp_g = (k % 2 == 0) ? 1 : 3;
`endif
            step("sparse");
            check("sparse:grant_seq", 32'(last_grant), 32'(exp_g));
        end

        // random traffic
        for (int k = 0; k < 400; k++) begin
            valid     = 4'($urandom());
            rsp_ready = ($urandom_range(0, 3) != 0);
            rand_ops();
            step("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/add_unit_arbiter.md
# add_unit_arbiter

Shares the single 8-bit carry-lookahead add datapath of the scalar pipelined processor between up to four requesters (e.g. ALU issue, address generation, PC increment). Performs round-robin arbitration with a per-requester valid/ready handshake, drives the shared adder, and returns a registered 12-bit result tagged with the winning requester's ID. It follows the adder's result convention: bits [11:8] are zero and the carry-out is dropped.

## Interface
- NUM_REQ, 2: number of requesters, legal range 2–4.
- WORD_W, 12: processor word width.
- ADD_W, 8: adder width; operand bits above ADD_W are ignored.
- ID_W, $clog2(NUM_REQ): width of the response tag.

- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- req_valid  input  NUM_REQ  per-requester operation valid.
- req_ready  output  NUM_REQ  per-requester accept; at most one bit is high.
- req_op_a  input  NUM_REQ*WORD_W  operand A; requester i occupies [i*WORD_W +: WORD_W].
- req_op_b  input  NUM_REQ*WORD_W  operand B; same packing as req_op_a.
- rsp_valid  output  1  result register holds a valid result.
- rsp_ready  input  1  consumer accepts the result.
- rsp_result  output  WORD_W  {zeros, (a[7:0]+b[7:0]) mod 256}.
- rsp_id  output  ID_W  index of the requester that produced the result.

## Operation
- slot_free = !rsp_valid || rsp_ready.
- When slot_free is high, the arbiter grants the first requester with valid high, searching from ptr upward modulo NUM_REQ. It raises req_ready for that requester only. A transfer occurs when both req_valid and req_ready are high.
- When slot_free is low, every req_ready bit is 0.
- req_ready may depend combinationally on req_valid and rsp_ready. Requesters must not make req_valid depend on req_ready.
- On a transfer from requester g:
  - the result register loads adder(op_a[7:0], op_b[7:0]) zero-extended to WORD_W;
  - rsp_id is set to g;
  - rsp_valid is set to 1;
  - ptr becomes (g+1) mod NUM_REQ.
- When rsp_ready is high and no transfer occurs, rsp_valid clears. rsp_result and rsp_id hold their values.
- When no requester is valid, ptr is unchanged.
- Arithmetic:
  - carry-out is discarded: 0xFF + 0x01 gives 0x000;
  - operand bits [11:8] have no effect;
  - result bits [11:8] are always 0.
- While rsp_valid is high and rsp_ready is low, rsp_result and rsp_id stay stable.

## Timing
- Latency is 1 cycle: a transfer at edge t produces rsp_valid high after edge t.
- Throughput is one operation per cycle when rsp_ready is held high. Simultaneous drain and accept in the same cycle is supported.
- A requester that holds req_valid high waits at most NUM_REQ−1 grants to other requesters (round-robin fairness).
- Reset values, applied asynchronously while rst_n is low:
  - rsp_valid = 0, rsp_result = 0, rsp_id = 0, ptr = 0;
  - req_ready = 0 while in reset.
- Reset in the middle of operation discards any held result. No transfer completes on the edge at which rst_n is low.

## Configuration
- ADD_ARB_FIXED_PRIO_EN defined: fixed priority. The lowest-index valid requester always wins, ptr is not implemented, and starvation of higher indices is allowed.
- ADD_ARB_FIXED_PRIO_EN undefined (default): round-robin as described above.
- The handshake, latency and arithmetic are identical in both builds.

## Structure
- A shared package holds:
  - WORD_W = 12 and ADD_W = 8 constants;
  - the requester ID typedef;
  - a grant-vector typedef.
- There is one sub-module, add_unit_core: the combinational 8-bit carry-lookahead adder (generate/propagate, two 4-bit lookahead groups). The arbiter instantiates it once, with its operands taken from a grant-driven operand multiplexer.

## Test plan
- Reset then idle: rsp_valid, rsp_result, rsp_id and every req_ready bit stay 0. Asserting rst_n low mid-stall clears rsp_valid immediately.
- Single requester, NUM_REQ=2: req 1 sends a=0x012, b=0x034 → rsp_valid next cycle with rsp_result=0x046 and rsp_id=1.
- Overflow and high bits: a=0xFFF, b=0x001 → rsp_result=0x000. A second case, a=0x980, b=0x380 → rsp_result=0x000; carry is dropped and bits [11:8] are ignored.
- Round-robin with all four requesters valid and rsp_ready=1: grants are 0,1,2,3,0 on consecutive cycles, each result tagged correctly. With ADD_ARB_FIXED_PRIO_EN, all grants go to requester 0.
- Backpressure: hold rsp_ready=0 with one result pending → every req_ready bit is 0 and the result/ID stay stable. Release rsp_ready with requester 2 valid → drain and new accept happen in the same cycle.
- Sparse arbitration: only requesters 1 and 3 valid, starting from ptr=0 → grants alternate 1,3,1,3.
